// File: rtl/project_types.sv
// project_types: shared arbiter state/owner enums and memory chip-enable levels.
package project_types;
  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_DONE} arb_state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;
  localparam logic CHIP_ENABLE = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and data ports, data first with a one-shot fetch fairness override.
module mem_arbiter
  import project_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [DATA_W/8-1:0] dm_sel,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [DATA_W/8-1:0] mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              bus_err,
  output logic              stallreq_if,
  output logic              stallreq_mem
);
  localparam int SW = DATA_W / 8;
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [SW-1:0]     sel;
    logic              we;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;
  arb_state_t state, state_nxt;
  owner_t owner, pick;
  mem_req_t if_r, dm_r, gnt_r;
  logic [CW-1:0] cnt;
  logic fair, abort, grant, hit, tmo;
  assign if_r = '{if_addr, {SW{1'b1}}, 1'b0, {DATA_W{1'b0}}};
  assign dm_r = '{dm_addr, dm_sel, dm_we, dm_wdata};
  // The ack cycle still sees the requester's old req, so arbitration waits for it to clear.
  assign grant = state == ARB_IDLE && !if_ack && !dm_ack && (if_req || dm_req);
  assign pick = (if_req && (!dm_req || fair)) ? OWN_IF : OWN_DM;
  assign gnt_r = pick == OWN_IF ? if_r : dm_r;
  assign hit = state == ARB_BUSY && mem_ready;
  assign tmo = state == ARB_BUSY && !mem_ready && cnt == CW'(TIMEOUT - 1);
  assign stallreq_if = if_req && !if_ack;
  assign stallreq_mem = dm_req && !dm_ack;
  always_comb begin
    state_nxt = state;
    state_nxt = grant ? ARB_BUSY : (hit || tmo) ? ARB_DONE : state == ARB_DONE ? ARB_IDLE : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ARB_IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner <= OWN_IF;
      mem_ce <= CHIP_DISABLE;
      mem_we <= 1'b0;
      mem_sel <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      bus_err <= 1'b0;
      fair <= 1'b0;
      abort <= 1'b0;
      cnt <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      bus_err <= 1'b0;
      if (grant) begin
        owner <= pick;
        mem_addr <= gnt_r.addr;
        mem_sel <= gnt_r.sel;
        mem_we <= gnt_r.we;
        mem_wdata <= gnt_r.wdata;
        mem_ce <= CHIP_ENABLE;
        cnt <= '0;
        abort <= 1'b0;
        if (pick == OWN_IF) fair <= 1'b0;
      end
      if (hit || tmo) begin
        mem_ce <= CHIP_DISABLE;
        abort <= tmo;
        if (owner == OWN_IF) if_rdata <= hit ? mem_rdata : '0;
        else dm_rdata <= hit ? mem_rdata : '0;
      end else if (state == ARB_BUSY) cnt <= cnt + 1'b1;
      if (state == ARB_DONE) begin
        if_ack <= owner == OWN_IF;
        dm_ack <= owner == OWN_DM;
        bus_err <= abort;
        if (owner == OWN_DM && if_req) fair <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench; expected completions are queued at request time and popped on each ack.
module tb_mem_arbiter;
  localparam logic [31:0] K = 32'h24020105;
  logic clk = 1'b0, rst = 1'b0;
  logic if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [3:0] dm_sel = '0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic if_ack, dm_ack, mem_ce, mem_we, mem_ready, bus_err, stallreq_if, stallreq_mem;
  logic [3:0] mem_sel;
  int cmp = 0, bad = 0, busy_cnt = 0, rdy_dly = 0, n;
  bit never = 1'b0;
  typedef struct {bit dm; logic [31:0] rdata; bit err;} exp_t;
  exp_t exp_q[$];

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_sel(dm_sel), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .bus_err(bus_err), .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
  );

  always #5 clk = ~clk;
  always @(posedge clk) busy_cnt <= mem_ce ? busy_cnt + 1 : 0;
  assign mem_ready = mem_ce && !never && busy_cnt == rdy_dly;
  assign mem_rdata = mem_addr ^ K;

  always @(negedge clk) begin : mon
    exp_t e;
    logic [31:0] r;
    if (rst && (if_ack || dm_ack)) begin
      cmp++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_ack: if_ack=%0b dm_ack=%0b with nothing expected", if_ack, dm_ack);
      end else begin
        e = exp_q.pop_front();
        r = dm_ack ? dm_rdata : if_rdata;
        if ({if_ack, dm_ack, r, bus_err} !== {!e.dm, e.dm, e.rdata, e.err}) begin
          bad++;
          $display("FAIL sb_ack: got if_ack=%0b dm_ack=%0b rdata=%h err=%0b, want dm=%0b rdata=%h err=%0b",
                   if_ack, dm_ack, r, bus_err, e.dm, e.rdata, e.err);
        end
      end
    end
  end

  task automatic wait_ack(input bit dm, output int cnt_o);
    cnt_o = 0;
    do begin @(negedge clk); cnt_o++; end while (!(dm ? dm_ack : if_ack) && cnt_o < 64);
  endtask

  task automatic test_reset();
    @(negedge clk);
    cmp++;
    if ({mem_ce, mem_we, mem_sel, mem_addr, mem_wdata, if_ack, dm_ack, bus_err, if_rdata, dm_rdata} !== '0) begin
      bad++;
      $display("FAIL reset_state: ce=%0b addr=%h ack=%0b%0b err=%0b rd=%h/%h, want all zero",
               mem_ce, mem_addr, if_ack, dm_ack, bus_err, if_rdata, dm_rdata);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h100;
    exp_q.push_back('{1'b0, 32'h24020005, 1'b0});
    @(negedge clk);
    cmp++;
    if ({mem_ce, mem_we, mem_sel, mem_addr, stallreq_if} !== {1'b1, 1'b0, 4'hF, 32'h100, 1'b1}) begin
      bad++;
      $display("FAIL fetch_grant: ce=%0b we=%0b sel=%h addr=%h stall=%0b, want 1 0 f 00000100 1",
               mem_ce, mem_we, mem_sel, mem_addr, stallreq_if);
    end
    wait_ack(1'b0, n);
    cmp++;
    if (n + 1 !== 3) begin bad++; $display("FAIL fetch_latency: got %0d cycles, want 3", n + 1); end
    cmp++;
    if (stallreq_if !== 1'b0) begin bad++; $display("FAIL fetch_stall_at_ack: got %0b, want 0", stallreq_if); end
    if_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    if_req = 1'b1; if_addr = 32'h104;
    dm_req = 1'b1; dm_we = 1'b0; dm_sel = 4'hF; dm_addr = 32'h200;
    exp_q.push_back('{1'b1, 32'h200 ^ K, 1'b0});
    exp_q.push_back('{1'b0, 32'h104 ^ K, 1'b0});
    @(negedge clk);
    cmp++;
    if (mem_addr !== 32'h200) begin bad++; $display("FAIL simul_first_grant: addr=%h, want 00000200", mem_addr); end
    wait_ack(1'b1, n);
    cmp++;
    if (n !== 2) begin bad++; $display("FAIL simul_dm_latency: got %0d, want 2", n); end
    dm_addr = 32'h208;
    exp_q.push_back('{1'b1, 32'h208 ^ K, 1'b0});
    wait_ack(1'b0, n);
    cmp++;
    if (n !== 4) begin bad++; $display("FAIL simul_fair_fetch: got %0d cycles, want 4", n); end
    if_req = 1'b0;
    wait_ack(1'b1, n);
    cmp++;
    if (n !== 4) begin bad++; $display("FAIL simul_second_dm: got %0d cycles, want 4", n); end
    dm_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    rdy_dly = 3;
    dm_req = 1'b1; dm_we = 1'b1; dm_sel = 4'b0011; dm_addr = 32'h300; dm_wdata = 32'hDEADBEEF;
    exp_q.push_back('{1'b1, 32'h300 ^ K, 1'b0});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmp++;
      if ({mem_ce, mem_we, mem_sel, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h300, 32'hDEADBEEF}) begin
        bad++;
        $display("FAIL write_stable[%0d]: ce=%0b we=%0b sel=%h addr=%h wd=%h, want 1 1 3 00000300 deadbeef",
                 i, mem_ce, mem_we, mem_sel, mem_addr, mem_wdata);
      end
    end
    wait_ack(1'b1, n);
    cmp++;
    if (n !== 2) begin bad++; $display("FAIL write_latency: got %0d, want 2", n); end
    dm_req = 1'b0; dm_we = 1'b0; rdy_dly = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    never = 1'b1;
    dm_req = 1'b1; dm_sel = 4'hF; dm_addr = 32'h400;
    exp_q.push_back('{1'b1, 32'h0, 1'b1});
    wait_ack(1'b1, n);
    cmp++;
    if (n !== 18) begin bad++; $display("FAIL timeout_latency: got %0d, want 18", n); end
    dm_req = 1'b0;
    @(negedge clk);
    cmp++;
    if ({dm_ack, bus_err, mem_ce} !== 3'b000) begin
      bad++;
      $display("FAIL timeout_after: ack=%0b err=%0b ce=%0b, want 000", dm_ack, bus_err, mem_ce);
    end
    never = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    never = 1'b1;
    if_req = 1'b1; if_addr = 32'h500;
    @(negedge clk);
    cmp++;
    if (mem_ce !== 1'b1) begin bad++; $display("FAIL rstmid_busy: ce=%0b, want 1", mem_ce); end
    #2 rst = 1'b0;
    #1;
    cmp++;
    if (mem_ce !== 1'b0) begin bad++; $display("FAIL rstmid_async: ce=%0b, want 0", mem_ce); end
    if_req = 1'b0;
    @(negedge clk);
    rst = 1'b1; never = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen |= if_ack | dm_ack;
    end
    cmp++;
    if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_no_ack: ack seen=%0b, want 0", seen); end
    if_req = 1'b1; if_addr = 32'h504;
    exp_q.push_back('{1'b0, 32'h504 ^ K, 1'b0});
    wait_ack(1'b0, n);
    cmp++;
    if (n !== 3) begin bad++; $display("FAIL rstmid_fresh: got %0d, want 3", n); end
    if_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    if_req = 1'b1; if_addr = 32'h600;
    exp_q.push_back('{1'b0, 32'h600 ^ K, 1'b0});
    wait_ack(1'b0, n);
    cmp++;
    if (n !== 3) begin bad++; $display("FAIL b2b_first: got %0d, want 3", n); end
    for (int k = 1; k < 4; k++) begin
      if_addr = 32'h600 + 32'(4 * k);
      exp_q.push_back('{1'b0, (32'h600 + 32'(4 * k)) ^ K, 1'b0});
      @(negedge clk);
      cmp++;
      if (mem_ce !== 1'b0) begin bad++; $display("FAIL b2b_dead[%0d]: ce=%0b, want 0", k, mem_ce); end
      wait_ack(1'b0, n);
      cmp++;
      if (n + 1 !== 4) begin bad++; $display("FAIL b2b_period[%0d]: got %0d, want 4", k, n + 1); end
    end
    if_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_simultaneous();
    test_write();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    cmp++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL sb_leftover: %0d pending, want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
